// File: rtl/fifo2pcie.sv
// Pops TLP beats from the TX TLP FIFO into a 2-entry queue and drives the PCIe core's 64-bit AXI-Stream TX port.
// Optional length checking and src_dsc marking is built when FIFO2PCIE_LEN_CHECK_EN is defined.

package pcie_tlp_pkg;
    localparam int unsigned PCIE_DATA_W     = 64;
    localparam int unsigned PCIE_KEEP_W     = PCIE_DATA_W / 8;
    localparam int unsigned PCIE_TUSER_TX_W = 4;

    typedef logic                       PCIE_TREADY64;
    typedef logic                       PCIE_TVALID64;
    typedef logic                       PCIE_TLAST64;
    typedef logic [PCIE_KEEP_W-1:0]     PCIE_TKEEP64;
    typedef logic [PCIE_DATA_W-1:0]     PCIE_TDATA64;
    typedef logic [PCIE_TUSER_TX_W-1:0] PCIE_TUSER64_TX;
endpackage

package nettlp_pkg;
    localparam int unsigned LEN_W = 16;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic [2:0]       fmt;
        logic [4:0]       pkttype;
        logic [7:0]       tag;
    } TLP_FIELD64;

    typedef struct packed {
        logic                        tvalid;
        pcie_tlp_pkg::PCIE_TLAST64    tlast;
        pcie_tlp_pkg::PCIE_TKEEP64    tkeep;
        pcie_tlp_pkg::PCIE_TDATA64    tdata;
        pcie_tlp_pkg::PCIE_TUSER64_TX tuser;
        TLP_FIELD64                   field;
    } TLP64_TX;

    typedef struct packed {
        logic    data_valid;
        TLP64_TX tlp;
    } PCIE_FIFO64_TX;

    typedef struct packed {
        pcie_tlp_pkg::PCIE_TLAST64    tlast;
        pcie_tlp_pkg::PCIE_TKEEP64    tkeep;
        pcie_tlp_pkg::PCIE_TDATA64    tdata;
        pcie_tlp_pkg::PCIE_TUSER64_TX tuser;
    } tx_beat_t;
endpackage

module fifo2pcie
    import pcie_tlp_pkg::*, nettlp_pkg::*;
(
    input  logic           pcie_clk,
    input  logic           pcie_rst,
    output logic           rd_en,
    input  PCIE_FIFO64_TX  dout,
    input  logic           empty,
    input  PCIE_TREADY64   pcie_tready,
    output PCIE_TVALID64   pcie_tvalid,
    output PCIE_TLAST64    pcie_tlast,
    output PCIE_TKEEP64    pcie_tkeep,
    output PCIE_TDATA64    pcie_tdata,
    output PCIE_TUSER64_TX pcie_tuser,
    output logic [15:0]    err_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_PKT, S_DISCARD} state_t;

    state_t     state_q, state_n;
    logic [1:0] occ_q, occ_n;
    logic [2:0] fill;
    logic       rd_q, pop, enq;
    tx_beat_t   q0_q, q1_q, q0_n, q1_n, beat;
    logic       unused_bits;

    assign pop = pcie_tvalid && pcie_tready;

    // In-flight read counts as occupied so a returning beat always has a slot
    assign fill  = 3'(occ_q) - 3'(pop) + 3'(rd_q);
    assign rd_en = !pcie_rst && !empty && (fill < 3'd2);

`ifdef FIFO2PCIE_LEN_CHECK_EN
    localparam int unsigned EXP_W     = LEN_W - 2;
    localparam int unsigned LEN_RND_W = LEN_W + 1;

    logic [EXP_W-1:0]     exp_q, exp_n, cnt_q, cnt_n, idx, exp_cur;
    logic [LEN_RND_W-1:0] len_rnd;
    logic                 err_inc;

    assign unused_bits = ^{dout.tlp.tvalid, dout.tlp.field, len_rnd[2:0]};
`else
    assign unused_bits = ^{dout.tlp.tvalid, dout.tlp.field};
`endif

    // FSM state register
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) state_q <= S_IDLE;
        else          state_q <= state_n;
    end

    // Next state and beat acceptance/modification
    always_comb begin
        state_n = state_q;
        enq     = 1'b0;
        beat    = '{tlast: dout.tlp.tlast, tkeep: dout.tlp.tkeep,
                    tdata: dout.tlp.tdata, tuser: dout.tlp.tuser};
`ifdef FIFO2PCIE_LEN_CHECK_EN
        exp_n   = exp_q;
        cnt_n   = cnt_q;
        err_inc = 1'b0;
        len_rnd = {1'b0, dout.tlp.field.len} + LEN_RND_W'(7);
        exp_cur = (state_q == S_IDLE) ? len_rnd[LEN_RND_W-1:3] : exp_q;
        idx     = (state_q == S_IDLE) ? EXP_W'(1) : cnt_q + EXP_W'(1);
`endif
        if (rd_q && dout.data_valid) begin
            case (state_q)
                S_IDLE, S_PKT: begin
                    enq     = 1'b1;
                    state_n = dout.tlp.tlast ? S_IDLE : S_PKT;
`ifdef FIFO2PCIE_LEN_CHECK_EN
                    exp_n = exp_cur;
                    cnt_n = idx;
                    if (dout.tlp.tlast && (idx < exp_cur)) begin
                        beat.tuser[3] = 1'b1;
                        err_inc       = 1'b1;
                    end else if (!dout.tlp.tlast && (idx >= exp_cur)) begin
                        beat.tlast = 1'b1;
                        err_inc    = 1'b1;
                        state_n    = S_DISCARD;
                    end
`endif
                end
                S_DISCARD: begin
                    if (dout.tlp.tlast) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Queue shift on pop, write into the first free slot on enqueue
    always_comb begin
        q0_n  = q0_q;
        q1_n  = q1_q;
        occ_n = occ_q - 2'(pop);
        if (pop) q0_n = q1_q;
        if (enq) begin
            if (occ_n == 2'd0) q0_n = beat;
            else               q1_n = beat;
            occ_n = occ_n + 2'd1;
        end
    end

    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            occ_q       <= '0;
            rd_q        <= 1'b0;
            q0_q        <= '0;
            q1_q        <= '0;
            pcie_tvalid <= 1'b0;
        end else begin
            occ_q       <= occ_n;
            rd_q        <= rd_en;
            q0_q        <= q0_n;
            q1_q        <= q1_n;
            pcie_tvalid <= (occ_n != 2'd0);
        end
    end

    assign pcie_tlast = q0_q.tlast;
    assign pcie_tkeep = q0_q.tkeep;
    assign pcie_tdata = q0_q.tdata;
    assign pcie_tuser = q0_q.tuser;

`ifdef FIFO2PCIE_LEN_CHECK_EN
    always_ff @(posedge pcie_clk) begin
        if (pcie_rst) begin
            exp_q   <= '0;
            cnt_q   <= '0;
            err_cnt <= '0;
        end else begin
            exp_q <= exp_n;
            cnt_q <= cnt_n;
            if (err_inc && (err_cnt != 16'hFFFF)) err_cnt <= err_cnt + 16'd1;
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule
